// File: rtl/trigger_capture_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trigger_capture_if : ADC sample stream and display read port bundle    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface trigger_capture_if #(
  parameter int WIDTH = 10
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic [9:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (output sample_valid, sample, rd_addr, input rd_data);
  modport slave  (input sample_valid, sample, rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trigger_capture : level-triggered, double-banked ADC frame capture     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module trigger_capture #(
  parameter int DEPTH        = 640,
  parameter int WIDTH        = 10,
  parameter int PRETRIG      = 320,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  trigger_capture_if.slave  bus,
  input  wire logic [WIDTH-1:0] i_level,
  input  wire logic         i_falling,
  input  wire logic         i_auto,
  input  wire logic         i_run,
  input  wire logic         i_arm,
  output logic              o_frame_valid,
  output logic              o_frame_done,
  output logic              o_auto_trig,
  output logic [1:0]        o_state
);

  localparam int        c_tw        = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [9:0] c_depth_m1  = 10'(DEPTH - 1);
  localparam logic [9:0] c_pretrig   = 10'(PRETRIG);
  localparam logic [9:0] c_post_len  = 10'(DEPTH - PRETRIG);
  localparam logic [10:0] c_depth11  = 11'(DEPTH);
  localparam logic [c_tw-1:0] c_timeout = c_tw'(AUTO_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    ARMED   = 2'd2,
    POST    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_wr_bank;
  logic [9:0]        r_wp;
  logic [9:0]        r_pre_cnt;
  logic [9:0]        r_post_cnt;
  logic [c_tw-1:0]   r_to_cnt;
  logic [9:0]        r_trig_ptr;
  logic [9:0]        r_disp_start;
  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_valid;
  logic              r_auto_flag;
  logic              r_frame_valid;
  logic              r_frame_done;
  logic              r_auto_trig;
  logic [WIDTH-1:0]  r_rd_data;
  logic [WIDTH-1:0]  r_mem [2][DEPTH];

  logic              w_accept;
  logic [9:0]        w_wp_next;
  logic              w_cross;
  logic [c_tw-1:0]   w_to_next;
  logic              w_force;
  logic              w_trig;
  logic              w_swap;
  logic [9:0]        w_ptr;
  logic [9:0]        w_start;
  logic              w_flag;
  logic [10:0]       w_sum;
  logic [10:0]       w_sub;
  logic              w_rd_ok;
  logic [9:0]        w_phys;

  assign w_accept  = bus.sample_valid && (r_state != IDLE);
  assign w_wp_next = (r_wp == c_depth_m1) ? 10'd0 : r_wp + 10'd1;

  assign w_cross = r_prev_valid &&
                   (i_falling ? ((r_prev > i_level) && (bus.sample <= i_level))
                              : ((r_prev < i_level) && (bus.sample >= i_level)));

  // Saturating so a long auto-off wait cannot wrap into a spurious timeout
  assign w_to_next = (r_to_cnt == c_timeout) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_force   = i_auto && (w_to_next == c_timeout) && !w_cross;
  assign w_trig    = w_accept && (r_state == ARMED) && (w_cross || w_force);

  assign w_swap = w_accept &&
                  (((r_state == POST) && (r_post_cnt == c_post_len - 10'd1)) ||
                   ((r_state == ARMED) && w_trig && (c_post_len == 10'd1)));

  assign w_ptr   = (r_state == POST) ? r_trig_ptr : r_wp;
  assign w_flag  = (r_state == POST) ? r_auto_flag : w_force;
  assign w_start = (w_ptr >= c_pretrig) ? (w_ptr - c_pretrig) : (w_ptr + c_post_len);

  // Sum is below 2*DEPTH for valid columns, so one conditional subtract wraps it
  assign w_sum   = {1'b0, r_disp_start} + {1'b0, bus.rd_addr};
  assign w_sub   = w_sum - c_depth11;
  assign w_rd_ok = ({1'b0, bus.rd_addr} < c_depth11) && r_frame_valid;
  assign w_phys  = !w_rd_ok ? 10'd0 : ((w_sum >= c_depth11) ? w_sub[9:0] : w_sum[9:0]);

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wp] <= bus.sample;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_wr_bank     <= 1'b0;
      r_wp          <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_to_cnt      <= '0;
      r_trig_ptr    <= '0;
      r_disp_start  <= '0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_auto_flag   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_auto_trig   <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_data    <= w_rd_ok ? r_mem[~r_wr_bank][w_phys] : '0;

      if (w_accept) begin
        r_wp         <= w_wp_next;
        r_prev       <= bus.sample;
        r_prev_valid <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_arm || i_run) begin
            r_state      <= PREFILL;
            r_wp         <= '0;
            r_pre_cnt    <= '0;
            r_to_cnt     <= '0;
            r_prev_valid <= 1'b0;
          end
        end
        PREFILL: begin
          if (w_accept) begin
            r_pre_cnt <= r_pre_cnt + 10'd1;
            r_to_cnt  <= '0;
            if (r_pre_cnt == c_pretrig - 10'd1) begin
              r_state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (w_accept) begin
            r_to_cnt <= w_to_next;
            if (w_trig) begin
              r_trig_ptr  <= r_wp;
              r_auto_flag <= w_force;
              r_post_cnt  <= 10'd1;
              r_state     <= POST;
            end
          end
        end
        POST: begin
          if (w_accept) begin
            r_post_cnt <= r_post_cnt + 10'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_swap) begin
        r_wr_bank     <= ~r_wr_bank;
        r_disp_start  <= w_start;
        r_auto_trig   <= w_flag;
        r_frame_valid <= 1'b1;
        r_frame_done  <= 1'b1;
        if (i_run) begin
          r_state      <= PREFILL;
          r_wp         <= '0;
          r_pre_cnt    <= '0;
          r_to_cnt     <= '0;
          r_prev_valid <= 1'b0;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_done  = r_frame_done;
  assign o_auto_trig   = r_auto_trig;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: doc/trigger_capture.md
# trigger_capture

Triggered acquisition buffer sitting between the ADC and the VGA renderer, in place of the free-running sample shift register. It watches the ADC sample stream for a programmable level crossing and captures a fixed window of samples around the trigger into one of two RAM banks. On frame completion it swaps banks, so the renderer always reads a complete, stable, trigger-aligned frame by pixel column.

## Interface
- DEPTH, 640: samples per frame (one per VGA column).
- WIDTH, 10: sample width (ADC resolution).
- PRETRIG, 320: samples kept before the trigger sample; 1 ≤ PRETRIG < DEPTH.
- AUTO_TIMEOUT, 4096: samples spent in ARMED before auto mode forces a trigger.
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sample_valid  in  1  one-cycle strobe; i_sample is accepted on cycles where this is 1.
- i_sample  in  WIDTH  ADC code.
- i_level  in  WIDTH  trigger level; sampled live.
- i_falling  in  1  0 selects rising-edge trigger, 1 selects falling-edge trigger.
- i_auto  in  1  enables the forced trigger after AUTO_TIMEOUT.
- i_run  in  1  1 re-arms after each frame; 0 stops in IDLE after the current frame.
- i_arm  in  1  one-cycle pulse; starts a capture from IDLE (ignored elsewhere).
- i_rd_addr  in  10  display column, 0..DEPTH-1.
- o_rd_data  out  WIDTH  registered sample for i_rd_addr.
- o_frame_valid  out  1  at least one frame has been swapped in since reset.
- o_frame_done  out  1  one-cycle pulse on bank swap.
- o_auto_trig  out  1  the displayed frame was force-triggered.
- o_state  out  2  IDLE=0, PREFILL=1, ARMED=2, POST=3.

## Operation
- Storage: two DEPTH×WIDTH banks. Capture writes wr_bank; reads use disp_bank = !wr_bank. Each bank has a circular write pointer wp (0..DEPTH-1) that wraps DEPTH-1→0. Every accepted sample writes mem[wr_bank][wp] and advances wp.
- IDLE: no writes. Leaves on i_arm=1, or when i_run=1, and enters PREFILL.
- Entering PREFILL: wp, the prefill count and the timeout count clear, and prev_valid clears.
- PREFILL: accepts PRETRIG samples, then goes to ARMED. No trigger can fire in this state, but prev is tracked.
- ARMED: keeps writing circularly. Trigger conditions on an accepted sample cur, with prev_valid=1:
  - rising: prev < i_level and cur ≥ i_level;
  - falling: prev > i_level and cur ≤ i_level.
- On trigger, trig_ptr is set to the wp of the trigger sample and the state moves to POST.
- Auto trigger: when i_auto=1 and the ARMED sample count reaches AUTO_TIMEOUT, that sample forces a trigger and sets auto_flag.
- POST: accepts DEPTH−PRETRIG samples, counting the trigger sample as the first. After the last one:
  - swap: disp_bank ← wr_bank, wr_bank toggles;
  - disp_start ← (trig_ptr − PRETRIG) mod DEPTH;
  - o_auto_trig ← auto_flag, o_frame_valid ← 1;
  - next state is PREFILL if i_run=1, otherwise IDLE.
- prev/prev_valid: updated on every accepted sample in PREFILL, ARMED and POST.
- Read mapping: phys = (disp_start + i_rd_addr) mod DEPTH, computed without overflow (compare-and-subtract). Column PRETRIG always holds the trigger sample.
- Read data is forced to 0 when i_rd_addr ≥ DEPTH or o_frame_valid=0.
- Reset values:
  - state IDLE, wr_bank=0, disp_bank=1, disp_start=0;
  - all counters and flags 0;
  - every output 0.
- RAM contents are not reset.

## Timing
- Sample acceptance, trigger evaluation and the RAM write all occur on the i_sample_valid cycle. The state change is visible the next cycle.
- o_frame_done is high for exactly one cycle, the cycle after the last POST sample is accepted. The swap, o_frame_valid and o_auto_trig update on the same edge.
- Read latency is 1 cycle: o_rd_data reflects the i_rd_addr of the previous cycle and the disp_bank/disp_start in effect on that cycle.
- The read port never accesses wr_bank, so there is no tearing.
- i_arm coinciding with the swap cycle is ignored.
- i_run falling during a capture finishes that frame, then goes to IDLE.
- Reset asserted mid-capture aborts immediately. o_frame_valid returns to 0, and the partial bank is never displayed.
- i_sample_valid may be high on consecutive cycles; throughput is 1 sample per cycle.

## Test plan
- Rising ramp: i_sample = 0,1,2,… (one per strobe), level=512, i_arm pulse. Required: trigger on 512; o_frame_done once; columns 0/320/639 read 192/512/831.
- Falling sawtooth: 1023 down to 0, repeating, i_falling=1, level=300. Required: column 320 reads 300 and column 319 reads 301.
- Auto: constant 100, level=512, i_auto=1. Required: POST entered after 4096 ARMED samples, o_auto_trig=1, all columns read 100. With i_auto=0 the block stays in ARMED indefinitely.
- Single-shot vs run: with i_run=0, one frame completes and o_state returns to 0. With i_run=1, three frames give three o_frame_done pulses, and bank reads are stable between pulses.
- Reset mid-POST, then re-arm with a new ramp. Required: o_frame_valid=0 and o_rd_data=0 until the new frame completes, and no data from before the reset appears.
- Read port: i_rd_addr=700 → 0. Changing the address each cycle must give the data one cycle later, including on the o_frame_done cycle.
